// File: rtl/ksa32_arb_pkg.sv
// Shared types and constants for the ksa32 arbiter slice.
// Holds the FSM state encoding, the datapath width and a clog2 helper.
package ksa32_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/KSA32_top.sv
// 32-bit Kogge-Stone adder, carry-in tied to zero.
// Ports: A, B operands; SUM = A+B mod 2^32; COUT carry out of bit 31;
//        OVERFLOW signed overflow of the two's-complement add.
module KSA32_top (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] SUM,
    output logic        COUT,
    output logic        OVERFLOW
);

    // Generate/propagate prefix trees, one row per doubling distance.
    logic [31:0] g [0:5];
    logic [31:0] p [0:5];

    always_comb begin
        g[0] = A & B;
        p[0] = A ^ B;
        for (int l = 1; l < 6; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << (l - 1))) begin
                    g[l][i] = g[l-1][i]
                            | (p[l-1][i] & g[l-1][i - (1 << (l - 1))]);
                    p[l][i] = p[l-1][i] & p[l-1][i - (1 << (l - 1))];
                end else begin
                    g[l][i] = g[l-1][i];
                    p[l][i] = p[l-1][i];
                end
            end
        end
    end

    // g[5][i] is the carry out of bit i; bit 0 has no carry in.
    assign SUM      = p[0] ^ {g[5][30:0], 1'b0};
    assign COUT     = g[5][31];
    assign OVERFLOW = (A[31] == B[31]) && (SUM[31] != A[31]);

endmodule

// File: rtl/ksa32_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
// Ports: req request vector, ptr search start; grant chosen index,
//        any_valid high when any request bit is set.
import ksa32_arb_pkg::*;

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_valid
);

    // Rotate by ptr, priority-encode, then map back to an absolute index.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        found     = 1'b0;
        any_valid = |req;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ksa32_arbiter.sv
// Shares one KSA32_top adder among NUM_REQ requesters (round robin).
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_a/req_b
//        per-requester handshake and packed operands; rsp_valid/
//        rsp_ready/rsp_sum/rsp_cout/rsp_overflow/rsp_id response port;
//        busy (not IDLE); ops_done (accepted responses, wrapping).
import ksa32_arb_pkg::*;

module ksa32_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_overflow,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          ops_done
);

    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              any_valid;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ID_W-1:0]   op_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              add_ovf;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // Adder sees registered operands only, never the request bus.
    KSA32_top u_add (
        .A        (op_a),
        .B        (op_b),
        .SUM      (add_sum),
        .COUT     (add_cout),
        .OVERFLOW (add_ovf)
    );

    // Operand mux for the granted slice.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: grant strobe only in IDLE and never during reset.
    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (state == IDLE && !rst && any_valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (grant == ID_W'(i));
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_id        <= '0;
            rsp_valid    <= 1'b0;
            rsp_sum      <= '0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_id       <= '0;
            ops_done     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_id  <= grant;
                        rr_ptr <= ptr_nxt;
                    end
                end
                EXEC: begin
                    rsp_sum      <= add_sum;
                    rsp_cout     <= add_cout;
                    rsp_overflow <= add_ovf;
                    rsp_id       <= op_id;
                    rsp_valid    <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
